// File: rtl/gpio_uart_streamer.sv
// ---------------------------------------------------------------------------
// gpio_uart_streamer
//
// Captures bytes from the memory controller's GPIO byte port into a small
// FIFO and streams them off-chip as 8N1 UART frames (LSB first). The writer
// can never be stalled: a byte arriving while the FIFO is full is dropped
// and a sticky overflow flag is raised.
//
// Parameters:
//   CLK_FREQ    clock frequency in Hz
//   BAUD        UART bit rate; one bit lasts CLK_FREQ / BAUD clocks
//   FIFO_DEPTH  byte entries, power of two, >= 2
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   GPIO       in   [7:0] byte from the memory controller
//   GPIOEn     in   write strobe, one byte per high cycle
//   clearOvf   in   synchronous clear of overflow (a same-edge drop wins)
//   tx         out  UART line, idle high, registered
//   busy       out  frame in flight or FIFO non-empty
//   overflow   out  sticky, set when a byte is dropped
//   fifoCount  out  [$clog2(FIFO_DEPTH):0] current FIFO occupancy
// ---------------------------------------------------------------------------
module gpio_uart_streamer #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    GPIO,
    input  logic                          GPIOEn,
    input  logic                          clearOvf,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Transmitter
    state_t           state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic bit_end;
    logic fifo_empty;
    logic push;
    logic drop;
    logic pop;

    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign fifo_empty = (count == '0);

    // Full is judged on the pre-edge count, so a pop on the same edge never
    // makes room for the byte being offered.
    assign push = GPIOEn && (count != CNT_FULL);
    assign drop = GPIOEn && (count == CNT_FULL);

    // The head is popped on the edge that enters START, either from IDLE or
    // straight from the end of STOP for gap-free back-to-back frames.
    assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));

    assign fifoCount = count;
    assign busy      = (state != IDLE) || !fifo_empty;

    // NOTE: the storage array has no reset; stale bytes are unreachable once
    // the count is zero, and leaving it out keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= GPIO;
        end
    end

    // NOTE: every clocked block uses non-blocking assignments so all state
    // updates see the same pre-edge values, matching the hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointers are PTR_W bits wide, so they wrap modulo the depth.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Set has priority over clear when both happen on one edge.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clearOvf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        tx    <= 1'b0;
                        state <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // The next bit is shift[1] before the shift lands.
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_uart_streamer.sv
// ---------------------------------------------------------------------------
// tb_gpio_uart_streamer
//
// Self-checking bench for gpio_uart_streamer at CLK_FREQ=1000, BAUD=100
// (10 clocks per bit) and FIFO_DEPTH=4. A frame-timer/queue reference model
// predicts tx, busy, overflow and fifoCount every cycle, and a line decoder
// recovers transmitted bytes for comparison with the bytes the model says
// were fully sent.
// ---------------------------------------------------------------------------
module tb_gpio_uart_streamer;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gpio      = 8'h00;
    logic       gpio_en   = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;

    gpio_uart_streamer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .GPIO      (gpio),
        .GPIOEn    (gpio_en),
        .clearOvf  (clear_ovf),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .fifoCount (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];      // bytes waiting in the FIFO
    logic [7:0] sent_q[$];   // bytes whose frame ran to completion
    logic [7:0] rx_q[$];     // bytes recovered from the line
    int         m_left;      // cycles left in the current frame, 0 = idle
    logic [7:0] m_cur;
    logic       m_ovf;
    int         cycle = 0;

    bit         rx_active;
    int         rx_cnt;
    logic [7:0] rx_shift;

    task automatic model_reset();
        m_q.delete();
        m_left    = 0;
        m_cur     = 8'h00;
        m_ovf     = 1'b0;
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_shift  = 8'h00;
    endtask

    function automatic logic model_tx();
        int pos;
        if (m_left == 0) return 1'b1;
        pos = (FRAME - m_left) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return m_cur[3'(pos - 1)];
    endfunction

    // Line decoder: first low cycle is the start of a frame, bits are
    // sampled mid-bit.
    task automatic rx_sample(input logic t);
        if (!rx_active && t == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
        end
        if (rx_active) begin
            if (rx_cnt == CPB / 2)
                check("start_bit", {31'b0, t}, 32'd0);
            if (rx_cnt > CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
                rx_shift = {t, rx_shift[7:1]};
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                check("stop_bit", {31'b0, t}, 32'd1);
                rx_q.push_back(rx_shift);
            end
            rx_cnt++;
            if (rx_cnt == FRAME) rx_active = 1'b0;
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the
    // falling edge.
    task automatic tick();
        int   size_b;
        bit   do_pop;
        bit   do_push;
        @(posedge clk);
        cycle++;
        if (rst) begin
            size_b = m_q.size();
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) sent_q.push_back(m_cur);
            end
            do_pop  = (m_left == 0) && (size_b > 0);
            do_push = gpio_en && (size_b < DEPTH);
            if (do_pop) begin
                m_cur  = m_q.pop_front();
                m_left = FRAME;
            end
            if (do_push) m_q.push_back(gpio);
            if (gpio_en && !do_push) m_ovf = 1'b1;
            else if (clear_ovf)      m_ovf = 1'b0;
        end
        @(negedge clk);
        rx_sample(tx);
        check($sformatf("cycle %0d {tx,busy,ovf,cnt}", cycle),
              {26'b0, tx, busy, overflow, fifo_count},
              {26'b0, model_tx(), (m_left != 0) || (m_q.size() != 0), m_ovf,
               3'(m_q.size())});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((busy || rx_active) && n < budget) begin
            tick();
            n++;
        end
        check("drain_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        check($sformatf("%s rx_count", tag), rx_q.size(), sent_q.size());
        n = (rx_q.size() < sent_q.size()) ? rx_q.size() : sent_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s rx_byte%0d", tag, i), {24'b0, rx_q[i]}, {24'b0, sent_q[i]});
        rx_q.delete();
        sent_q.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        gpio    = b;
        gpio_en = 1'b1;
        tick();
        gpio_en = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;      // tx per bit slot: [0]=start ... [9]=stop
        int         busy_fall;  // cycles after the write edge
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t_fall;
        int idle_bad;

        vecs[0] = '{8'hA5, 10'b1101001010, 101};
        vecs[1] = '{8'h00, 10'b1000000000, 101};
        vecs[2] = '{8'hFF, 10'b1111111110, 101};
        vecs[3] = '{8'h5A, 10'b1010110100, 101};
        vecs[4] = '{8'h01, 10'b1000000010, 101};
        vecs[5] = '{8'h80, 10'b1100000000, 101};

        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset {tx,busy,ovf,cnt}", {28'b0, tx, busy, overflow, fifo_count[0]},
              {28'b0, 4'b1000});
        check("reset fifo_count", {29'b0, fifo_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single-byte frames from the table
        for (int v = 0; v < 6; v++) begin
            write_byte(vecs[v].data);
            for (int k = 1; k <= 105; k++) begin
                tick();
                if ((k - 1) < FRAME && ((k - 1) % CPB) == CPB / 2)
                    check($sformatf("vec%0d bit%0d", v, (k - 1) / CPB), {31'b0, tx},
                          {31'b0, vecs[v].frame[(k - 1) / CPB]});
                if (k == vecs[v].busy_fall - 1)
                    check($sformatf("vec%0d busy_before_fall", v), {31'b0, busy}, 32'd1);
                if (k == vecs[v].busy_fall)
                    check($sformatf("vec%0d busy_fall", v), {31'b0, busy}, 32'd0);
            end
            compare_rx($sformatf("vec%0d", v));
        end

        // Burst of three: occupancy 1,1,2 and contiguous frames
        write_byte(8'h01);
        check("burst cnt E0", {29'b0, fifo_count}, 32'd1);
        write_byte(8'h02);
        check("burst cnt E1", {29'b0, fifo_count}, 32'd1);
        write_byte(8'h03);
        check("burst cnt E2", {29'b0, fifo_count}, 32'd2);
        t_fall = 2;
        while (busy && t_fall < 400) begin
            tick();
            t_fall++;
        end
        check("burst busy_fall_edge", t_fall, 32'd301);
        drain(200);
        check("burst rx_count", rx_q.size(), 32'd3);
        if (rx_q.size() == 3) begin
            check("burst rx0", {24'b0, rx_q[0]}, 32'h01);
            check("burst rx1", {24'b0, rx_q[1]}, 32'h02);
            check("burst rx2", {24'b0, rx_q[2]}, 32'h03);
        end
        compare_rx("burst");

        // Overflow, clear, and clear-vs-drop on the same edge
        for (int i = 0; i < 6; i++) begin
            write_byte(8'h10 + 8'(i));
            if (i == 4) check("ovf before drop", {31'b0, overflow}, 32'd0);
            if (i == 5) check("ovf after drop", {31'b0, overflow}, 32'd1);
        end
        check("ovf fifo full", {29'b0, fifo_count}, 32'd4);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf cleared", {31'b0, overflow}, 32'd0);
        clear_ovf = 1'b1;
        write_byte(8'h16);
        clear_ovf = 1'b0;
        check("ovf set beats clear", {31'b0, overflow}, 32'd1);
        check("ovf still full", {29'b0, fifo_count}, 32'd4);
        drain(700);
        check("ovf rx_count", rx_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check($sformatf("ovf rx%0d", i), {24'b0, rx_q[i]}, 32'h10 + i);
        compare_rx("ovf");

        // Reset in the middle of a frame with two bytes queued
        write_byte(8'h33);
        write_byte(8'h44);
        write_byte(8'h55);
        check("rst queued", {29'b0, fifo_count}, 32'd2);
        for (int i = 0; i < 44; i++) tick();
        check("rst tx low before", {31'b0, tx}, 32'd0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rst tx immediate", {31'b0, tx}, 32'd1);
        check("rst fifo_count", {29'b0, fifo_count}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst overflow", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        check("rst no frames after", rx_q.size(), 32'd0);
        compare_rx("rst_quiet");
        write_byte(8'h5A);
        drain(200);
        check("rst rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) check("rst rx 5A", {24'b0, rx_q[0]}, 32'h5A);
        compare_rx("rst_after");

        // Idle line
        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) idle_bad++;
        end
        check("idle bad cycles", idle_bad, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            gpio      = 8'($urandom);
            gpio_en   = ($urandom_range(0, 39) == 0) || (i % 700 < 6);
            clear_ovf = ($urandom_range(0, 99) == 0);
            tick();
        end
        gpio_en   = 1'b0;
        clear_ovf = 1'b0;
        drain(1000);
        compare_rx("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
